// File: rtl/hc_sr04_echo_emulator.sv
// HC-SR04 sensor-side emulator: answers a controller's trigger with an echo pulse whose width encodes an APB-programmed distance.
// Optional build macro HC_SR04_ECHO_EMU_IRQ_EN adds the done flag, CTRL.IRQ_EN and the irq output.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a synchronised trigger rise with EN set
// S_TRIG_HI | trigger high, measuring its width in us (saturating)
// S_BURST   | emulated ultrasonic burst delay before the echo rises
// S_ECHO    | echo driven high for the latched length
module hc_sr04_echo_emulator #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int US_PER_CM   = 58,
    parameter int BURST_US    = 200,
    parameter int MIN_TRIG_US = 10,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        trigger,
    output logic        echo
`ifdef HC_SR04_ECHO_EMU_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int          CYC_PER_US = CLK_FREQ / 1_000_000;
    localparam logic [15:0] PRE_RELOAD = 16'(CYC_PER_US - 1);
    localparam logic [15:0] MIN_US     = 16'(MIN_TRIG_US);
    localparam logic [15:0] BURST_LOAD = 16'(BURST_US - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO
    } state_t;

    state_t      state_q, state_d;
    logic        trig_s1, trig_s2, trig_s3;
    logic        trig_rise, trig_fall;
    logic        ctrl_en;
    logic [8:0]  dist_cm;
    logic        short_trig;
    logic [7:0]  trig_cnt;
    logic [15:0] len_q;
    logic [15:0] pre_cnt;
    logic [15:0] us_cnt;
    logic        pre_tick;
    logic        trig_long;
    logic        inc_cnt;
    logic        set_short;
    logic        dist_ok;
    logic [15:0] dist_len;
    logic [15:0] echo_len;
    logic        apb_access;
    logic        apb_wr;
    logic [3:0]  addr;
    logic        wr_ctrl;
    logic        wr_dist;
    logic        clr;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = &{1'b0, PADDR[31:4], PWDATA[31:9]};

    assign apb_access = PSEL & PENABLE;
    assign apb_wr     = apb_access & PREADY & PWRITE;
    assign addr       = PADDR[3:0];
    assign wr_ctrl    = apb_wr && (addr == 4'h0);
    assign wr_dist    = apb_wr && (addr == 4'h4);
    assign clr        = wr_ctrl & PWDATA[1];

    assign trig_rise  = trig_s2 & ~trig_s3;
    assign trig_fall  = ~trig_s2 & trig_s3;

    assign pre_tick   = (pre_cnt == 16'd0);
    // Counting the tick of the current cycle makes a pulse of exactly MIN_TRIG_US acceptable.
    assign trig_long  = (us_cnt >= MIN_US) || ((us_cnt == MIN_US - 16'd1) && pre_tick);

    assign dist_ok    = (dist_cm >= 9'd2) && (dist_cm <= 9'(MAX_CM));
    assign dist_len   = 16'(dist_cm) * 16'(US_PER_CM);
    assign echo_len   = dist_ok ? dist_len : 16'(TIMEOUT_US);

`ifdef HC_SR04_ECHO_EMU_IRQ_EN
    logic irq_en;
    logic done;
    logic done_set;
    logic wr_status;

    assign wr_status = apb_wr && (addr == 4'h8);
    assign done_set  = (state_q == S_ECHO) && (state_d == S_IDLE) && ctrl_en;
    assign irq       = done & irq_en;

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= PWDATA[2];
            if (done_set) done <= 1'b1;
            else if (clr || (wr_status && PWDATA[2])) done <= 1'b0;
        end
    end
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trigger;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    always_comb begin
        state_d   = state_q;
        inc_cnt   = 1'b0;
        set_short = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_rise) state_d = S_TRIG_HI;
            end
            S_TRIG_HI: begin
                if (trig_fall) begin
                    if (trig_long) begin
                        state_d = S_BURST;
                        inc_cnt = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        set_short = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (pre_tick && (us_cnt == 16'd0)) state_d = S_ECHO;
            end
            S_ECHO: begin
                if (pre_tick && (us_cnt == 16'd0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Dropping EN aborts whatever is in progress without counting it.
        if (!ctrl_en) begin
            state_d   = S_IDLE;
            inc_cnt   = 1'b0;
            set_short = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q <= S_IDLE;
            echo    <= 1'b0;
            pre_cnt <= 16'd0;
            us_cnt  <= 16'd0;
            len_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            echo    <= (state_d == S_ECHO);
            if ((state_d == S_BURST) && (state_q != S_BURST)) len_q <= echo_len;
            if (state_d != state_q) begin
                pre_cnt <= PRE_RELOAD;
                case (state_d)
                    S_BURST: us_cnt <= BURST_LOAD;
                    S_ECHO:  us_cnt <= len_q - 16'd1;
                    default: us_cnt <= 16'd0;
                endcase
            end else begin
                pre_cnt <= pre_tick ? PRE_RELOAD : pre_cnt - 16'd1;
                case (state_q)
                    S_TRIG_HI: if (pre_tick && (us_cnt < MIN_US)) us_cnt <= us_cnt + 16'd1;
                    S_BURST, S_ECHO: if (pre_tick && (us_cnt != 16'd0)) us_cnt <= us_cnt - 16'd1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            ctrl_en    <= 1'b0;
            dist_cm    <= 9'd0;
            short_trig <= 1'b0;
            trig_cnt   <= 8'd0;
        end else begin
            if (wr_ctrl) ctrl_en <= PWDATA[0];
            if (wr_dist) dist_cm <= PWDATA[8:0];
            if (clr) begin
                short_trig <= 1'b0;
                trig_cnt   <= 8'd0;
            end else begin
                if (set_short) short_trig <= 1'b1;
                if (inc_cnt) trig_cnt <= trig_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            4'h0: begin
                rdata[0] = ctrl_en;
`ifdef HC_SR04_ECHO_EMU_IRQ_EN
                rdata[2] = irq_en;
`endif
            end
            4'h4: rdata[8:0] = dist_cm;
            4'h8: begin
                rdata[0]    = (state_q != S_IDLE);
                rdata[1]    = short_trig;
`ifdef HC_SR04_ECHO_EMU_IRQ_EN
                rdata[2]    = done;
`endif
                rdata[15:8] = trig_cnt;
            end
            default: rdata = 32'd0;
        endcase
    end

    // One wait state: PREADY rises on the second access cycle, read data lands with it.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= 32'd0;
        end else begin
            PREADY <= apb_access & ~PREADY;
            PRDATA <= (apb_access & ~PREADY & ~PWRITE) ? rdata : 32'd0;
        end
    end

endmodule

// File: doc/hc_sr04_echo_emulator.md
Name: hc_sr04_echo_emulator

Overview:
- APB-programmable model of the HC-SR04 sensor end of the trigger/echo protocol.
- Accepts the trigger pulse from an HC-SR04 controller and returns an echo pulse whose width encodes a software-programmed distance.
- Used for on-FPGA loopback of the ultrasonic controller without a physical sensor; sits on the APB peripheral bus beside the other PERI blocks.

Parameters:
- CLK_FREQ, 100_000_000, PCLK frequency in Hz.
- US_PER_CM, 58, echo microseconds per cm.
- BURST_US, 200, delay from accepted trigger fall to echo rise, in us.
- MIN_TRIG_US, 10, minimum trigger high width accepted, in us.
- MAX_CM, 400, largest valid distance; outside the range 2..MAX_CM the block produces a timeout echo.
- TIMEOUT_US, 38000, echo width for no-target, in us.

Ports:
- PCLK  in  1  single clock.
- PRESET  in  1  reset, synchronous, active-low.
- PADDR  in  32  APB address; only [3:0] decoded.
- PWRITE  in  1  APB write.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- trigger  in  1  asynchronous trigger from controller.
- echo  out  1  emulated echo pulse.

Behaviour:
- Reset (PRESET=0 at PCLK edge):
  - echo=0, PREADY=0, PRDATA=0.
  - All registers 0; FSM to IDLE; synchroniser flops 0.
- APB:
  - One wait state. PREADY is registered and goes high on the second access-phase cycle (PSEL&PENABLE) for exactly one cycle.
  - Writes commit once, in the PREADY cycle. PRDATA is valid in the PREADY cycle.
- Register map (PADDR[3:0]):
  - 0x0 CTRL: bit0 EN (rw). Bit1 CLR: write-1 clears STATUS counters and flags; self-clearing, reads 0.
  - 0x4 DIST: [8:0] distance_cm (rw); upper bits read 0.
  - 0x8 STATUS (ro): bit0 busy (state≠IDLE); bit1 short_trig (sticky); [15:8] accepted trigger count, 8-bit, wraps 255→0.
  - 0xC and other offsets: reads return 0, writes are ignored.
- Trigger input path:
  - 2-flop synchroniser, then 1 flop for edge detection. The internal rise/fall is seen 3 PCLK cycles after the pin edge.
- Timing base:
  - CYC_PER_US = CLK_FREQ/1_000_000.
  - The prescaler and us-counter restart on every state entry, so every timed interval is an exact multiple of CYC_PER_US cycles.
- FSM:
  - IDLE: echo=0. On synced trigger rise with EN=1 → TRIG_HI. A rise with EN=0 is ignored.
  - TRIG_HI: counts high time in us, saturating at MIN_TRIG_US. On synced fall:
    - count≥MIN_TRIG_US → BURST; trigger count +1; echo length latched.
    - otherwise → IDLE and set short_trig.
  - Echo length latched on entry to BURST: distance_cm×US_PER_CM if 2≤distance_cm≤MAX_CM, else TIMEOUT_US. 16-bit counter; maximum is 400×58=23200.
  - BURST: lasts BURST_US us → ECHO.
  - ECHO: echo=1, registered, for exactly latched_len×CYC_PER_US cycles → IDLE with echo=0.
- Echo rise timing: exactly 3 + BURST_US×CYC_PER_US PCLK cycles after the trigger pin falls.
- Trigger edges during BURST/ECHO are ignored and not counted.
- DIST writes during BURST/ECHO do not affect the pulse in progress.
- EN cleared while not IDLE: FSM goes to IDLE on the next cycle and echo=0; the pulse is truncated and the trigger count is unchanged.
- CLR in the same cycle as a count increment: CLR wins.
- Reset mid-operation: echo=0 on the next edge; no residual pulse.

Optional Feature:
- Macro: HC_SR04_ECHO_EMU_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - STATUS bit2 done sets on ECHO→IDLE completion (not on abort). Writing 1 to STATUS bit2 clears it.
  - irq = done & CTRL bit2 (IRQ_EN, rw).
  - If set and clear happen in the same cycle, set wins.
- When undefined:
  - No irq port.
  - STATUS bit2 and CTRL bit2 read 0; writes to them are ignored.

Test Plan:
- EN=1, DIST=100, 12us trigger pulse → echo rises 3+20000 cycles after the trigger fall; high for exactly 580000 cycles; STATUS[15:8]=1, busy=0 afterwards.
- EN=1, 5us trigger → no echo, short_trig=1, count unchanged; CLR write → STATUS reads 0.
- DIST=0 and, separately, DIST=401 → echo high 3,800,000 cycles (timeout).
- DIST=10, second 12us trigger issued mid-echo → single echo of 58000 cycles; count=1.
- EN cleared 1000 cycles into echo → echo low on the next cycle, busy=0; PRESET=0 mid-BURST → no echo, all registers 0.
- APB: write DIST=0x1FF, read back 0x1FF; read 0xC → 0; PREADY high exactly one cycle per access; a single write commits once.
